// File: rtl/vector_exec_pkg.sv
// Shared types and helpers for the time-multiplexed vector execute unit.
// Optional build macro VECTOR_EXEC_SAT_EN enables signed saturating ADD/SUB.
package vector_exec_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_AND = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of beats needed to sweep all lanes through the physical ALUs.
    function automatic int beats(input int lanes, input int phys);
        return lanes / phys;
    endfunction

endpackage

// File: rtl/vector_exec_if.sv
// Operand/result handshake bundle between the ID/EX muxes, the vector
// execute unit and the EX/MEM segment. With VECTOR_EXEC_SAT_EN defined the
// bundle also carries the sat_any flag.
interface vector_exec_if
    import vector_exec_pkg::*;
#(
    parameter int LANES = 6,
    parameter int EW    = 32
) ();

    logic                  in_valid;
    logic                  in_ready;
    alu_op_t               op;
    logic                  vector_op;
    logic [LANES*EW-1:0]   a;
    logic [LANES*EW-1:0]   b;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*EW-1:0]   result;
    logic                  flag_z;
    logic                  busy;
`ifdef VECTOR_EXEC_SAT_EN
    logic                  sat_any;
`endif

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, op, vector_op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_z, busy
`ifdef VECTOR_EXEC_SAT_EN
        , input sat_any
`endif
    );

    // The execute unit itself.
    modport slave (
        input  in_valid, op, vector_op, a, b, out_ready,
        output in_ready, out_valid, result, flag_z, busy
`ifdef VECTOR_EXEC_SAT_EN
        , output sat_any
`endif
    );

endinterface

// File: rtl/vector_exec_lane.sv
// One combinational EW-bit lane ALU. Default build wraps modulo 2^EW on
// ADD/SUB; with VECTOR_EXEC_SAT_EN defined ADD/SUB are signed and saturate,
// and sat_o reports the clamp.
module vector_exec_lane
    import vector_exec_pkg::*;
#(
    parameter int EW = 32
) (
    input  alu_op_t        op_i,
    input  logic [EW-1:0]  a_i,
    input  logic [EW-1:0]  b_i,
`ifdef VECTOR_EXEC_SAT_EN
    output logic           sat_o,
`endif
    output logic [EW-1:0]  y_o
);

    logic [EW-1:0] sum;
    logic [EW-1:0] diff;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;

`ifdef VECTOR_EXEC_SAT_EN
    localparam logic [EW-1:0] SMAX = {1'b0, {(EW-1){1'b1}}};
    localparam logic [EW-1:0] SMIN = {1'b1, {(EW-1){1'b0}}};

    logic ovf_add;
    logic ovf_sub;

    // Signed overflow: operands agree (ADD) / disagree (SUB) in sign and the
    // wrapped result flips away from the sign of a.
    assign ovf_add = (a_i[EW-1] == b_i[EW-1]) && (sum[EW-1]  != a_i[EW-1]);
    assign ovf_sub = (a_i[EW-1] != b_i[EW-1]) && (diff[EW-1] != a_i[EW-1]);

    // Lane result with per-lane saturation on signed ADD/SUB.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        y_o   = '0;
        sat_o = 1'b0;
        unique case (op_i)
            OP_ADD: begin
                y_o   = ovf_add ? (a_i[EW-1] ? SMIN : SMAX) : sum;
                sat_o = ovf_add;
            end
            OP_SUB: begin
                y_o   = ovf_sub ? (a_i[EW-1] ? SMIN : SMAX) : diff;
                sat_o = ovf_sub;
            end
            OP_MUL: y_o = a_i * b_i;
            OP_AND: y_o = a_i & b_i;
            default: y_o = '0;
        endcase
    end
`else
    // Lane result with modular wraparound.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        y_o = '0;
        unique case (op_i)
            OP_ADD: y_o = sum;
            OP_SUB: y_o = diff;
            OP_MUL: y_o = a_i * b_i;
            OP_AND: y_o = a_i & b_i;
            default: y_o = '0;
        endcase
    end
`endif

endmodule

// File: rtl/vector_exec_unit.sv
// Time-multiplexed vector execute unit: a LANES-element vector is processed
// on PHYS_LANES lane ALUs over LANES/PHYS_LANES beats, with valid/ready on
// both sides and a single-beat scalar mode (lane 0 only).
// Optional build macro VECTOR_EXEC_SAT_EN: signed saturating ADD/SUB plus
// the sat_any output.
module vector_exec_unit
    import vector_exec_pkg::*;
#(
    parameter int LANES      = 6,
    parameter int EW         = 32,
    parameter int PHYS_LANES = 2
) (
    input  logic            clk,
    input  logic            rst,
    vector_exec_if.slave    bus
);

    localparam int BEATS = beats(LANES, PHYS_LANES);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((LANES % PHYS_LANES) != 0) begin : g_bad_cfg
        $error("vector_exec_unit: LANES must be a multiple of PHYS_LANES");
    end

    state_t                state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [LANES*EW-1:0]   result_q, result_d;
    logic                  flag_z_q, flag_z_d;
    logic [LANES*EW-1:0]   a_q, b_q;
    alu_op_t               op_q;
    logic                  vec_q;
    logic                  accept;
    logic                  last_beat;
    int                    elem_base;
    logic [EW-1:0]         lane_y [PHYS_LANES];
`ifdef VECTOR_EXEC_SAT_EN
    logic                  sat_q, sat_d;
    logic                  lane_sat [PHYS_LANES];
`endif

    assign accept    = (state_q == IDLE) && bus.in_valid;
    assign last_beat = !vec_q || (beat_q == BW'(BEATS - 1));
    assign elem_base = int'(beat_q) * PHYS_LANES;

    // Physical lane p works on element beat*PHYS_LANES + p.
    for (genvar p = 0; p < PHYS_LANES; p++) begin : g_lane
        vector_exec_lane #(.EW(EW)) u_lane (
            .op_i (op_q),
            .a_i  (a_q[(elem_base + p) * EW +: EW]),
            .b_i  (b_q[(elem_base + p) * EW +: EW]),
`ifdef VECTOR_EXEC_SAT_EN
            .sat_o(lane_sat[p]),
`endif
            .y_o  (lane_y[p])
        );
    end

    // Control state and result registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            result_q <= '0;
            flag_z_q <= 1'b0;
`ifdef VECTOR_EXEC_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            beat_q   <= beat_d;
            result_q <= result_d;
            flag_z_q <= flag_z_d;
`ifdef VECTOR_EXEC_SAT_EN
            sat_q    <= sat_d;
`endif
        end
    end

    // Operand capture on accept.
    // NOTE: operand flops carry no reset; they are only read in RUN, after an accept has loaded them.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            op_q  <= bus.op;
            vec_q <= bus.vector_op;
        end
    end

    // Next-state, beat sequencing and lane write-back.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        result_d = result_q;
        flag_z_d = flag_z_q;
`ifdef VECTOR_EXEC_SAT_EN
        sat_d    = sat_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d  = RUN;
                    beat_d   = '0;
                    result_d = '0;
`ifdef VECTOR_EXEC_SAT_EN
                    sat_d    = 1'b0;
`endif
                end
            end
            RUN: begin
                for (int p = 0; p < PHYS_LANES; p++) begin
                    // Scalar mode only ever writes element 0.
                    if (vec_q || (p == 0)) begin
                        result_d[(elem_base + p) * EW +: EW] = lane_y[p];
`ifdef VECTOR_EXEC_SAT_EN
                        sat_d = sat_d | lane_sat[p];
`endif
                    end
                end
                if (last_beat) begin
                    state_d  = DONE;
                    beat_d   = '0;
                    flag_z_d = (result_d == '0);
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;
    assign bus.flag_z    = flag_z_q;
`ifdef VECTOR_EXEC_SAT_EN
    assign bus.sat_any   = sat_q;
`endif

endmodule

// File: tb/tb_vector_exec_unit.sv
// Directed self-checking bench for vector_exec_unit: default 6/2 instance
// plus 8/4 and 8/8 instances for the parametric cases. Honours
// VECTOR_EXEC_SAT_EN when the design is built with it.
module tb_vector_exec_unit;
    import vector_exec_pkg::*;

    localparam int EW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   assert_cnt = 0;
    int   fail_cnt   = 0;

    always #5 clk = ~clk;

    vector_exec_if #(.LANES(6), .EW(EW)) bus0 ();
    vector_exec_if #(.LANES(8), .EW(EW)) bus1 ();
    vector_exec_if #(.LANES(8), .EW(EW)) bus2 ();

    vector_exec_unit #(.LANES(6), .EW(EW), .PHYS_LANES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    vector_exec_unit #(.LANES(8), .EW(EW), .PHYS_LANES(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    vector_exec_unit #(.LANES(8), .EW(EW), .PHYS_LANES(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Shared drive for the two 8-lane instances.
    logic          p_valid = 1'b0;
    alu_op_t       p_op    = OP_ADD;
    logic          p_vec   = 1'b1;
    logic [255:0]  p_a     = '0;
    logic [255:0]  p_b     = '0;
    logic          p_out_ready = 1'b0;

    assign bus1.in_valid  = p_valid;
    assign bus1.op        = p_op;
    assign bus1.vector_op = p_vec;
    assign bus1.a         = p_a;
    assign bus1.b         = p_b;
    assign bus1.out_ready = p_out_ready;
    assign bus2.in_valid  = p_valid;
    assign bus2.op        = p_op;
    assign bus2.vector_op = p_vec;
    assign bus2.a         = p_a;
    assign bus2.b         = p_b;
    assign bus2.out_ready = p_out_ready;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present an op on bus0 for exactly the accepting edge; returns #1 after it.
    task automatic start_op(input alu_op_t o, input logic vec,
                            input logic [191:0] av, input logic [191:0] bv);
        bus0.op        = o;
        bus0.vector_op = vec;
        bus0.a         = av;
        bus0.b         = bv;
        bus0.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid  = 1'b0;
    endtask

    // Count edges after the accept until out_valid, bounded.
    task automatic wait_done(input string tag, input int exp_lat);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus0.out_valid && n < 20);
        check(tag, n, exp_lat);
    endtask

    task automatic release_result();
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [191:0] va, vb, ve;
        logic [255:0] sq;
        int n1, n2;

        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b0;
        bus0.op        = OP_ADD;
        bus0.vector_op = 1'b1;
        bus0.a         = '0;
        bus0.b         = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  bus0.in_ready,  1);
        check("rst_out_valid", bus0.out_valid, 0);
        check("rst_busy",      bus0.busy,      0);
        check("rst_result",    bus0.result,    0);
        check("rst_flag_z",    bus0.flag_z,    0);
`ifdef VECTOR_EXEC_SAT_EN
        check("rst_sat_any",   bus0.sat_any,   0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;

        // Vector ADD: 1..6 + 10 -> 11..16, latency 3.
        for (int i = 0; i < 6; i++) begin
            va[i*32 +: 32] = 32'(i + 1);
            vb[i*32 +: 32] = 32'd10;
        end
        ve = {32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11};
        start_op(OP_ADD, 1'b1, va, vb);
        check("add_busy", bus0.busy, 1);
        wait_done("add_latency", 3);
        check("add_result", bus0.result, ve);
        check("add_flag_z", bus0.flag_z, 0);
`ifdef VECTOR_EXEC_SAT_EN
        check("add_sat_any", bus0.sat_any, 0);
`endif
        release_result();
        check("add_back_idle", bus0.in_ready, 1);

        // SUB boundary: modular wrap, or signed saturation when enabled.
`ifdef VECTOR_EXEC_SAT_EN
        va = {6{32'h8000_0000}};
        vb = {6{32'h0000_0001}};
        ve = {6{32'h8000_0000}};
`else
        va = '0;
        vb = {6{32'h0000_0001}};
        ve = {6{32'hFFFF_FFFF}};
`endif
        start_op(OP_SUB, 1'b1, va, vb);
        wait_done("sub_latency", 3);
        check("sub_result", bus0.result, ve);
        check("sub_flag_z", bus0.flag_z, 0);
`ifdef VECTOR_EXEC_SAT_EN
        check("sub_sat_any", bus0.sat_any, 1);
`endif
        release_result();

        // Scalar AND: lane 0 ANDs to zero, other lanes stay zero despite nonzero operands.
        va = {{5{32'h1111_1111}}, 32'hF0F0_F0F0};
        vb = {{5{32'hFFFF_FFFF}}, 32'h0F0F_0F0F};
        start_op(OP_AND, 1'b0, va, vb);
        wait_done("and_latency", 1);
        check("and_result", bus0.result, 0);
        check("and_flag_z", bus0.flag_z, 1);
        release_result();

        // Scalar ADD: only lane 0 written.
        va = {{5{32'h0000_0005}}, 32'h0000_0007};
        vb = {{5{32'h0000_0009}}, 32'h0000_0003};
        start_op(OP_ADD, 1'b0, va, vb);
        wait_done("sadd_latency", 1);
        check("sadd_result", bus0.result, {160'h0, 32'h0000_000A});
        release_result();

        // Vector MUL with low-bits truncation, then backpressure.
        va = {32'h8000_0001, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2};
        vb = {6{32'd3}};
        ve = {32'h8000_0003, 32'd18, 32'd15, 32'd12, 32'd9, 32'd6};
        start_op(OP_MUL, 1'b1, va, vb);
        bus0.out_ready = 1'b1;  // ignored while running
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        check("mul_still_busy", bus0.out_valid, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mul_valid", bus0.out_valid, 1);
        check("mul_result", bus0.result, ve);
        // Offer a new op while the result is held.
        for (int i = 0; i < 6; i++) begin
            bus0.a[i*32 +: 32] = 32'(i + 1);
            bus0.b[i*32 +: 32] = 32'd10;
        end
        bus0.op        = OP_ADD;
        bus0.vector_op = 1'b1;
        bus0.in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_result_%0d", k),    bus0.result,    ve);
            check($sformatf("bp_in_ready_%0d", k),  bus0.in_ready,  0);
            check($sformatf("bp_out_valid_%0d", k), bus0.out_valid, 1);
        end
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        check("bp_release_ready", bus0.in_ready, 1);
        check("bp_not_accepted",  bus0.busy,     0);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        check("bp_accepted", bus0.busy, 1);
        wait_done("bp_add_latency", 3);
        check("bp_add_result", bus0.result,
              {32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11});
        release_result();

        // Reset mid-RUN aborts the operation.
        va = {6{32'h0000_0001}};
        vb = {6{32'h0000_0002}};
        start_op(OP_ADD, 1'b1, va, vb);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("mrst_in_ready",  bus0.in_ready,  1);
        check("mrst_out_valid", bus0.out_valid, 0);
        check("mrst_result",    bus0.result,    0);
        check("mrst_busy",      bus0.busy,      0);
        rst = 1'b1;
        @(posedge clk); #1;
        start_op(OP_ADD, 1'b1, va, vb);
        wait_done("mrst_recover_latency", 3);
        check("mrst_recover_result", bus0.result, {6{32'h0000_0003}});
        release_result();

        // Parametric: 8 lanes on 4 and on 8 physical ALUs, MUL a=b=lane index.
        for (int i = 0; i < 8; i++) begin
            p_a[i*32 +: 32] = 32'(i);
            p_b[i*32 +: 32] = 32'(i);
        end
        sq = {32'd49, 32'd36, 32'd25, 32'd16, 32'd9, 32'd4, 32'd1, 32'd0};
        p_op    = OP_MUL;
        p_vec   = 1'b1;
        p_valid = 1'b1;
        @(posedge clk); #1;
        p_valid = 1'b0;
        n1 = 0;
        n2 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus1.out_valid && n1 == 0) n1 = k;
            if (bus2.out_valid && n2 == 0) n2 = k;
            if (n1 != 0 && n2 != 0) break;
        end
        check("p84_latency", n1, 2);
        check("p88_latency", n2, 1);
        check("p84_result", bus1.result, sq);
        check("p88_result", bus2.result, sq);
        check("p84_flag_z", bus1.flag_z, 0);
        p_out_ready = 1'b1;
        @(posedge clk); #1;
        p_out_ready = 1'b0;
        check("p84_idle", bus1.in_ready, 1);
        check("p88_idle", bus2.in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
